pwrbtn_pulse_sched: RTL and testbench

Shared power-button pulse scheduler for the power-sequence CPLD. Several requesters (BMC, front-panel logic, watchdog) need to drive one active-low button pulse toward the chipset. This block arbitrates them round-robin and times each pulse at short or long width against the free-running 1 ms tick. It enforces a minimum released gap between pulses and reports grant and completion per requester.

---
 rtl/pwrbtn_pulse_sched.sv | 138 +++++++++++++
 tb/tb_pwrbtn_pulse_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwrbtn_pulse_sched.sv
// Round-robin power-button pulse scheduler.
// Times short/long active-low pulses on a 1 ms tick, then a release gap.
module pwrbtn_pulse_sched #(
  parameter int NUM_REQ  = 3,
  parameter int SHORT_MS = 200,
  parameter int LONG_MS  = 4000,
  parameter int GAP_MS   = 100,
  parameter int CNT_W    = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1ms,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_long,
  input  logic               abort,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               pulse_n,
  output logic               busy
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] SHORT_T = CNT_W'(SHORT_MS - 1);
  localparam logic [CNT_W-1:0] LONG_T  = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_MS - 1);
  localparam logic [IW-1:0]    LAST    = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IW-1:0]      ptr, ptr_d;
  logic [IW-1:0]      owner, owner_d;
  logic               is_long, is_long_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               pulse_n_d, busy_d;

  logic [IW-1:0]      win;
  logic               found;
  int                 j;
  logic [CNT_W-1:0]   term;

  // Round-robin winner search starting at ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ptr_d     = ptr;
    owner_d   = owner;
    is_long_d = is_long;
    grant_d   = '0;
    done_d    = '0;
    pulse_n_d = pulse_n;
    term      = is_long ? LONG_T : SHORT_T;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d        = PULSE;
          owner_d        = win;
          is_long_d      = req_long[win];
          grant_d[win]   = 1'b1;
          pulse_n_d      = 1'b0;
          cnt_d          = '0;
          ptr_d          = (win == LAST) ? '0 : win + 1'b1;
        end
      end
      PULSE: begin
        if (abort || (tick_1ms && cnt == term)) begin
          state_d   = GAP;
          pulse_n_d = 1'b1;
          cnt_d     = '0;
        end else if (tick_1ms) begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        if (tick_1ms && cnt == GAP_T) begin
          state_d       = IDLE;
          done_d[owner] = 1'b1;
          cnt_d         = '0;
        end else if (tick_1ms) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pulse_n_d = 1'b1;
        cnt_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset releases the button at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      owner   <= '0;
      is_long <= 1'b0;
      grant   <= '0;
      done    <= '0;
      pulse_n <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      is_long <= is_long_d;
      grant   <= grant_d;
      done    <= done_d;
      pulse_n <= pulse_n_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_pwrbtn_pulse_sched.sv
// Directed bench for pwrbtn_pulse_sched.
// Ticks every 10 clocks; widths counted from pre-edge samples.
module tb_pwrbtn_pulse_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1ms;
  logic [2:0] req;
  logic [2:0] req_long;
  logic       abort;
  logic [2:0] grant;
  logic [2:0] done;
  logic       pulse_n;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int phase = 0;
  int low_ticks = 0;
  int gap_ticks = 0;
  int done_cnt = 0;
  bit overlap = 1'b0;
  bit bad_busy = 1'b0;
  logic [2:0] gexp [4];
  logic [2:0] bitv;

  pwrbtn_pulse_sched #(
    .NUM_REQ (3),
    .SHORT_MS(3),
    .LONG_MS (6),
    .GAP_MS  (2),
    .CNT_W   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1ms(tick_1ms),
    .req     (req),
    .req_long(req_long),
    .abort   (abort),
    .grant   (grant),
    .done    (done),
    .pulse_n (pulse_n),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    logic pp, pb, t;
    tick_1ms = (phase == 9);
    phase = (phase == 9) ? 0 : phase + 1;
    pp = pulse_n;
    pb = busy;
    t = tick_1ms;
    @(posedge clk);
    #1;
    if (t && !pp) low_ticks++;
    if (t && pp && pb) gap_ticks++;
    if ((grant & done) != 3'b000) overlap = 1'b1;
    if (done != 3'b000) done_cnt++;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bad_busy = 1'b0;
    while (done == 3'b000 && n < 300) begin
      cyc();
      n++;
      if (done == 3'b000 && !busy) bad_busy = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(done != 3'b000), 1);
  endtask

  task automatic start(input logic [2:0] r, input logic [2:0] rl);
    req = r;
    req_long = rl;
    low_ticks = 0;
    gap_ticks = 0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    tick_1ms = 1'b0;
    req = '0;
    req_long = '0;
    abort = 1'b0;
    repeat (3) cyc();
    chk("rst_pulse_n", 32'(pulse_n), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    cyc();

    // single short request
    start(3'b001, 3'b000);
    chk("short_grant", 32'(grant), 32'h1);
    chk("short_pulse_low", 32'(pulse_n), 0);
    chk("short_busy", 32'(busy), 1);
    req = '0;
    cyc();
    chk("short_grant_1cyc", 32'(grant), 0);
    wait_done("short");
    chk("short_done", 32'(done), 32'h1);
    chk("short_width", 32'(low_ticks), 3);
    chk("short_gap", 32'(gap_ticks), 2);
    chk("short_busy_hold", 32'(bad_busy), 0);
    chk("short_busy_end", 32'(busy), 0);
    cyc();
    chk("short_done_1cyc", 32'(done), 0);

    // long width, req_long toggled mid-pulse
    start(3'b010, 3'b010);
    chk("long_grant", 32'(grant), 32'h2);
    req = '0;
    repeat (15) cyc();
    req_long = 3'b000;
    wait_done("long");
    chk("long_done", 32'(done), 32'h2);
    chk("long_width", 32'(low_ticks), 6);
    cyc();

    // round-robin from ptr=0 after an idle reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    gexp[0] = 3'b001;
    gexp[1] = 3'b010;
    gexp[2] = 3'b100;
    gexp[3] = 3'b001;
    req = 3'b111;
    req_long = 3'b000;
    for (int k = 0; k < 4; k++) begin
      low_ticks = 0;
      gap_ticks = 0;
      cyc();
      chk($sformatf("rr_grant%0d", k), 32'(grant), 32'(gexp[k]));
      bitv = grant;
      req = req & ~bitv;
      wait_done($sformatf("rr%0d", k));
      chk($sformatf("rr_done%0d", k), 32'(done), 32'(gexp[k]));
      chk($sformatf("rr_width%0d", k), 32'(low_ticks), 3);
      chk($sformatf("rr_gap%0d", k), 32'(gap_ticks), 2);
      if (k < 3) req = req | bitv;
    end
    req = '0;
    cyc();

    // abort one tick into a long pulse, then abort during gap
    start(3'b001, 3'b001);
    chk("ab_grant", 32'(grant), 32'h1);
    req = '0;
    for (int n = 0; n < 100 && low_ticks < 1; n++) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_release", 32'(pulse_n), 1);
    chk("ab_width", 32'(low_ticks), 1);
    repeat (3) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_gap_pulse_n", 32'(pulse_n), 1);
    chk("ab_gap_busy", 32'(busy), 1);
    wait_done("ab");
    chk("ab_done", 32'(done), 32'h1);
    chk("ab_gap", 32'(gap_ticks), 2);
    cyc();

    // abort coincident with terminal tick
    start(3'b010, 3'b000);
    chk("abt_grant", 32'(grant), 32'h2);
    req = '0;
    for (int n = 0; n < 100 && low_ticks < 2; n++) cyc();
    while (phase != 9) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abt_release", 32'(pulse_n), 1);
    chk("abt_width", 32'(low_ticks), 3);
    wait_done("abt");
    chk("abt_done", 32'(done), 32'h2);
    chk("abt_gap", 32'(gap_ticks), 2);
    cyc();

    // tick on the grant edge is not counted
    while (phase != 9) cyc();
    start(3'b100, 3'b000);
    chk("tg_grant", 32'(grant), 32'h4);
    req = '0;
    wait_done("tg");
    chk("tg_width", 32'(low_ticks), 3);
    chk("tg_done", 32'(done), 32'h4);
    cyc();

    // reset mid-pulse
    start(3'b010, 3'b000);
    req = '0;
    repeat (12) cyc();
    chk("mr_pre_low", 32'(pulse_n), 0);
    rst = 1'b1;
    #2;
    chk("mr_pulse_n", 32'(pulse_n), 1);
    chk("mr_busy", 32'(busy), 0);
    cyc();
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) cyc();
    chk("mr_no_done", 32'(done_cnt), 0);
    start(3'b100, 3'b000);
    chk("mr_grant", 32'(grant), 32'h4);
    req = '0;
    wait_done("mr");
    chk("mr_done", 32'(done), 32'h4);

    chk("grant_done_overlap", 32'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
